// File: rtl/vertex_clip_transform_if.sv
// Vertex stream bus for vertex_clip_transform: projection matrix, vertex input
// handshake and clip-space result handshake.
interface vertex_clip_transform_if #(
   parameter int WI = 8,
   parameter int WF = 8
);
   localparam int W = WI + WF;

   logic [15:0][W-1:0] projection_matrix;
   logic               in_valid;
   logic               in_ready;
   logic [W-1:0]       in_x;
   logic [W-1:0]       in_y;
   logic [W-1:0]       in_z;
   logic               out_valid;
   logic               out_ready;
   logic [W-1:0]       out_x;
   logic [W-1:0]       out_y;
   logic [W-1:0]       out_z;
   logic [W-1:0]       out_w;
   logic               overflow;

   modport master (
      output projection_matrix, in_valid, in_x, in_y, in_z, out_ready,
      input  in_ready, out_valid, out_x, out_y, out_z, out_w, overflow
   );

   modport slave (
      input  projection_matrix, in_valid, in_x, in_y, in_z, out_ready,
      output in_ready, out_valid, out_x, out_y, out_z, out_w, overflow
   );
endinterface

// File: rtl/vertex_clip_transform.sv
// 4x4 matrix times {x,y,z,1} using one time-shared MAC (16 cycles per vertex),
// with round-half-up and saturation of each clip-space component.
module vertex_clip_transform #(
   parameter int WI = 8,
   parameter int WF = 8
) (
   input logic                    Clk,
   input logic                    Reset,
   vertex_clip_transform_if.slave bus
);
   localparam int W  = WI + WF;
   localparam int AW = 2 * W + 2;

   localparam logic [W-1:0]         ONE_FX  = {{(WI-1){1'b0}}, 1'b1, {WF{1'b0}}};
   localparam logic signed [AW-1:0] RND_ADD = {{(AW-WF){1'b0}}, 1'b1, {(WF-1){1'b0}}};
   localparam logic signed [AW-1:0] MAX_FX  = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [AW-1:0] MIN_FX  = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_r;
   state_t                  state_nx_s;
   logic [3:0]              cnt_r;
   logic signed [AW-1:0]    acc_r;
   logic signed [AW-1:0]    acc_sum_s;
   logic [15:0][W-1:0]      mat_r;
   logic [3:0][W-1:0]       vec_r;
   logic [3:0][W-1:0]       res_r;
   logic                    ovf_sticky_r;
   logic                    overflow_r;
   logic                    in_ready_r;
   logic                    out_valid_r;
   logic signed [W-1:0]     m_sel_s;
   logic signed [W-1:0]     v_sel_s;
   logic signed [2*W-1:0]   prod_s;
   logic [W:0]              sat_s;

   // Returns {saturated, value}: round half up, drop WF fraction bits, clamp to W bits.
   function automatic logic [W:0] round_saturate(input logic signed [AW-1:0] a);
      logic signed [AW-1:0] rounded;
      logic signed [AW-1:0] shifted;
      logic [W:0]           result;
      rounded = a + RND_ADD;
      shifted = rounded >>> WF;
      if (shifted > MAX_FX) begin
         result = {1'b1, MAX_FX[W-1:0]};
      end else if (shifted < MIN_FX) begin
         result = {1'b1, MIN_FX[W-1:0]};
      end else begin
         result = {1'b0, shifted[W-1:0]};
      end
      return result;
   endfunction

   // MAC datapath: select element m(r,c) and v(c), multiply, accumulate, round/saturate.
   always_comb begin
      m_sel_s   = mat_r[cnt_r];
      v_sel_s   = vec_r[cnt_r[1:0]];
      prod_s    = m_sel_s * v_sel_s;
      acc_sum_s = acc_r + {{2{prod_s[2*W-1]}}, prod_s};
      sat_s     = round_saturate(acc_sum_s);
   end

   // Next-state logic for the IDLE/CALC/DONE sequencer.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.in_valid) begin
               state_nx_s = CALC;
            end else begin
               state_nx_s = IDLE;
            end
         end
         CALC: begin
            if (cnt_r == 4'd15) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = CALC;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DONE;
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // State register plus handshake flags registered from the next state.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         in_ready_r  <= (state_nx_s == IDLE);
         out_valid_r <= (state_nx_s == DONE);
      end
   end

   // Operand latch, accumulator, row results and overflow flags.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cnt_r        <= 4'd0;
         acc_r        <= '0;
         mat_r        <= '0;
         vec_r        <= '0;
         res_r        <= '0;
         ovf_sticky_r <= 1'b0;
         overflow_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid) begin
                  mat_r        <= bus.projection_matrix;
                  vec_r        <= {ONE_FX, bus.in_z, bus.in_y, bus.in_x};
                  acc_r        <= '0;
                  cnt_r        <= 4'd0;
                  ovf_sticky_r <= 1'b0;
               end
            end
            CALC: begin
               cnt_r <= cnt_r + 4'd1;
               if (cnt_r[1:0] == 2'd3) begin
                  res_r[cnt_r[3:2]] <= sat_s[W-1:0];
                  ovf_sticky_r      <= ovf_sticky_r | sat_s[W];
                  acc_r             <= '0;
               end else begin
                  acc_r <= acc_sum_s;
               end
               // The visible overflow only updates when the whole vertex is finished.
               if (cnt_r == 4'd15) begin
                  overflow_r <= ovf_sticky_r | sat_s[W];
               end
            end
            DONE: begin
               acc_r <= acc_r;
            end
            default: begin
               cnt_r <= 4'd0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_x     = res_r[0];
   assign bus.out_y     = res_r[1];
   assign bus.out_z     = res_r[2];
   assign bus.out_w     = res_r[3];
   assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_vertex_clip_transform.sv
// Self-checking bench for vertex_clip_transform: directed vectors plus random
// matrices/vertices against an integer-arithmetic reference model.
module tb_vertex_clip_transform;
   typedef logic [15:0][15:0] mat_t;
   typedef logic [3:0][15:0]  vec4_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   vertex_clip_transform_if #(.WI(8), .WF(8)) bus ();

   vertex_clip_transform #(.WI(8), .WF(8)) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic mat_t identity_m();
      mat_t m;
      m = '0;
      for (int i = 0; i < 4; i++) m[5*i] = 16'h0100;
      return m;
   endfunction

   // Reference: exact integer dot products, round half up, floor shift, clamp.
   function automatic void model(input mat_t m, input logic [15:0] x, input logic [15:0] y,
                                 input logic [15:0] z, output vec4_t res, output logic ov);
      longint v[4];
      longint s;
      v[0] = longint'($signed(x));
      v[1] = longint'($signed(y));
      v[2] = longint'($signed(z));
      v[3] = 256;
      ov = 1'b0;
      for (int r = 0; r < 4; r++) begin
         s = 0;
         for (int c = 0; c < 4; c++) s += longint'($signed(m[4*r+c])) * v[c];
         s = (s + 128) >>> 8;
         if (s > 32767) begin
            res[r] = 16'h7FFF; ov = 1'b1;
         end else if (s < -32768) begin
            res[r] = 16'h8000; ov = 1'b1;
         end else begin
            res[r] = s[15:0];
         end
      end
   endfunction

   function automatic mat_t random_m(input int mode);
      mat_t m;
      for (int e = 0; e < 16; e++) begin
         if (mode == 0) m[e] = 16'($urandom);
         else           m[e] = 16'($urandom_range(0, 1023) - 512);
      end
      return m;
   endfunction

   // Drives one vertex through both handshakes; reports results, latency and timeouts.
   task automatic run_vertex(input mat_t m, input logic [15:0] x, input logic [15:0] y,
                             input logic [15:0] z, input int swap_at,
                             output vec4_t res, output logic ov, output int lat, output bit to);
      int w;
      to = 1'b0;
      @(negedge clk);
      bus.projection_matrix = m;
      bus.in_x = x; bus.in_y = y; bus.in_z = z;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      w = 0;
      while (!bus.in_ready && w < 50) begin
         @(negedge clk); w++;
      end
      if (!bus.in_ready) to = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(negedge clk); lat++;
         if (lat == swap_at) bus.projection_matrix = '0;
      end
      if (!bus.out_valid) to = 1'b1;
      res = {bus.out_w, bus.out_z, bus.out_y, bus.out_x};
      ov  = bus.overflow;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.projection_matrix = '0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.in_x = '0; bus.in_y = '0; bus.in_z = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_handshake: in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
      end
      n_checks++;
      if ({bus.out_w, bus.out_z, bus.out_y, bus.out_x, bus.overflow} !== 65'd0) begin
         n_fail++; $display("FAIL reset_outputs: got %h %h %h %h ov=%b expected zeros", bus.out_x, bus.out_y, bus.out_z, bus.out_w, bus.overflow);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_release: in_ready=%b expected 1", bus.in_ready);
      end
   endtask

   task automatic test_identity();
      vec4_t res; logic ov; int lat; bit to;
      run_vertex(identity_m(), 16'h0180, 16'hFE00, 16'h0300, -1, res, ov, lat, to);
      n_checks++;
      if (to || res !== {16'h0100, 16'h0300, 16'hFE00, 16'h0180} || ov !== 1'b0) begin
         n_fail++; $display("FAIL identity: got %h ov=%b to=%0d expected 0100030 0fe000180 ov=0", res, ov, to);
      end
      n_checks++;
      if (lat != 16) begin
         n_fail++; $display("FAIL identity_latency: got %0d expected 16", lat);
      end
   endtask

   task automatic test_projection();
      mat_t m; vec4_t res; logic ov; int lat; bit to;
      m = '0;
      m[0] = 16'h0100; m[5] = 16'h0100; m[10] = 16'hFE00; m[15] = 16'h0000;
      m[11] = 16'h0300; m[14] = 16'h0100;
      run_vertex(m, 16'h0200, 16'h0100, 16'hFE00, -1, res, ov, lat, to);
      n_checks++;
      if (to || res !== {16'hFE00, 16'h0700, 16'h0100, 16'h0200} || ov !== 1'b0) begin
         n_fail++; $display("FAIL projection: got %h ov=%b expected fe00070001000200 ov=0", res, ov);
      end
   endtask

   task automatic test_saturation();
      mat_t m; vec4_t res; logic ov; int lat; bit to;
      m = identity_m();
      m[0] = 16'h7F00;
      run_vertex(m, 16'h0200, 16'h0000, 16'h0000, -1, res, ov, lat, to);
      n_checks++;
      if (to || res !== {16'h0100, 16'h0000, 16'h0000, 16'h7FFF} || ov !== 1'b1) begin
         n_fail++; $display("FAIL saturation: got %h ov=%b expected 0100000000007fff ov=1", res, ov);
      end
      run_vertex(identity_m(), 16'h0040, 16'h0080, 16'hFFC0, -1, res, ov, lat, to);
      n_checks++;
      if (to || res !== {16'h0100, 16'hFFC0, 16'h0080, 16'h0040} || ov !== 1'b0) begin
         n_fail++; $display("FAIL overflow_clear: got %h ov=%b expected 0100ffc000800040 ov=0", res, ov);
      end
   endtask

   task automatic test_random();
      mat_t m; vec4_t res, exp_res; logic ov, exp_ov; int lat; bit to;
      logic [15:0] x, y, z;
      for (int i = 0; i < 24; i++) begin
         m = random_m(i % 2);
         x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
         model(m, x, y, z, exp_res, exp_ov);
         run_vertex(m, x, y, z, -1, res, ov, lat, to);
         n_checks++;
         if (to || res !== exp_res || ov !== exp_ov || lat != 16) begin
            n_fail++; $display("FAIL random_%0d: got %h ov=%b lat=%0d expected %h ov=%b lat=16", i, res, ov, lat, exp_res, exp_ov);
         end
      end
   endtask

   task automatic test_backpressure();
      mat_t m; vec4_t exp_res; logic exp_ov; int lat;
      m = random_m(1);
      model(m, 16'h0123, 16'hFF10, 16'h0200, exp_res, exp_ov);
      @(negedge clk);
      bus.projection_matrix = m;
      bus.in_x = 16'h0123; bus.in_y = 16'hFF10; bus.in_z = 16'h0200;
      bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(negedge clk); lat++;
      end
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if ({bus.out_w, bus.out_z, bus.out_y, bus.out_x} !== exp_res || bus.overflow !== exp_ov
             || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL backpressure_%0d: got %h%h%h%h ov=%b rdy=%b vld=%b expected %h ov=%b rdy=0 vld=1",
                               i, bus.out_w, bus.out_z, bus.out_y, bus.out_x, bus.overflow, bus.in_ready, bus.out_valid, exp_res, exp_ov);
         end
         bus.in_valid = i[0];
         bus.in_x = 16'($urandom);
         bus.projection_matrix = random_m(0);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL backpressure_release: in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_matrix_change();
      mat_t m; vec4_t res, exp_res; logic ov, exp_ov; int lat; bit to;
      m = random_m(1);
      model(m, 16'h0300, 16'hFD80, 16'h0140, exp_res, exp_ov);
      run_vertex(m, 16'h0300, 16'hFD80, 16'h0140, 3, res, ov, lat, to);
      n_checks++;
      if (to || res !== exp_res || ov !== exp_ov) begin
         n_fail++; $display("FAIL matrix_change: got %h ov=%b expected %h ov=%b", res, ov, exp_res, exp_ov);
      end
   endtask

   task automatic test_reset_mid();
      mat_t m; vec4_t res, exp_res; logic ov, exp_ov; int lat; bit to;
      @(negedge clk);
      bus.projection_matrix = identity_m();
      bus.in_x = 16'h0500; bus.in_y = 16'h0600; bus.in_z = 16'h0700;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (7) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1
          || {bus.out_w, bus.out_z, bus.out_y, bus.out_x, bus.overflow} !== 65'd0) begin
         n_fail++; $display("FAIL reset_mid: vld=%b rdy=%b out=%h%h%h%h ov=%b expected 0/1 zeros",
                            bus.out_valid, bus.in_ready, bus.out_w, bus.out_z, bus.out_y, bus.out_x, bus.overflow);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_release: in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
      end
      m = random_m(1);
      model(m, 16'h0080, 16'hFF00, 16'h0240, exp_res, exp_ov);
      run_vertex(m, 16'h0080, 16'hFF00, 16'h0240, -1, res, ov, lat, to);
      n_checks++;
      if (to || res !== exp_res || ov !== exp_ov || lat != 16) begin
         n_fail++; $display("FAIL reset_mid_fresh: got %h ov=%b lat=%0d expected %h ov=%b lat=16", res, ov, lat, exp_res, exp_ov);
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_projection();
      test_saturation();
      test_random();
      test_backpressure();
      test_matrix_change();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/vertex_clip_transform.md
# vertex_clip_transform

Sequential matrix–vector stage that sits directly downstream of `get_projection_matrix`. It applies the 4×4 projection (or composed MVP) matrix to a stream of object-space vertices, producing homogeneous clip-space coordinates for the perspective-divide/rasterizer stage. A single time-shared multiplier-accumulator computes one output vector in 16 MAC cycles. Both input and output use valid/ready handshakes.

## Interface
- `WI`, default 8: integer bits of every fixed-point word, including sign.
- `WF`, default 8: fractional bits of every fixed-point word. Word width is W = WI+WF.
- `Clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `Reset` input, 1 bit: asynchronous, active-high reset.
- `projection_matrix` input, [15:0][W-1:0]: row-major matrix, element (r,c) at index 4r+c, signed Q(WI.WF). This is the same packing `get_projection_matrix` produces.
- `in_valid` input, 1 bit: a vertex is offered.
- `in_ready` output, 1 bit: the block can accept a vertex.
- `in_x`, `in_y`, `in_z` input, W bits each: vertex coordinates, signed Q(WI.WF). The homogeneous w is implicitly 1.0.
- `out_valid` output, 1 bit: the result is held on the out_* ports.
- `out_ready` input, 1 bit: the consumer accepts the result.
- `out_x`, `out_y`, `out_z`, `out_w` output, W bits each: clip-space result, signed Q(WI.WF).
- `overflow` output, 1 bit: at least one of the four results of this vertex saturated.

## Operation
- The state machine has three states: IDLE, CALC and DONE.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- **IDLE, on `in_valid` && `in_ready`:**
  - Latch all 16 matrix elements and the vector v = {in_x, in_y, in_z, 1.0} into internal registers.
  - Clear the accumulator, the counter `cnt` and the sticky overflow flag.
  - Go to CALC.
  - The matrix ports may change freely after the handshake; the latched copy is used for the whole vertex.
- **CALC, once per cycle, with `cnt` = 0..15, r = `cnt`[3:2], c = `cnt`[1:0]:**
  - acc += m(r,c) × v(c). Each product is a full-precision signed 2W-bit value; the accumulator is 2W+2 bits.
  - When c == 3:
    - Round by adding 2^(WF−1), then arithmetic right shift by WF (round-half-up).
    - Saturate to [−2^(W−1), 2^(W−1)−1] and write the result to output register r (0 = x, 1 = y, 2 = z, 3 = w).
    - If saturation occurred, set the sticky overflow flag.
    - Clear the accumulator.
  - After `cnt` == 15, go to DONE.
- **DONE:** out_* and `overflow` are held stable. On `out_ready`, go to IDLE.
- While the state is not IDLE, `in_valid` is ignored and no input is consumed.
- Output registers and `overflow` keep their values outside DONE. A consumer samples them only when `out_valid` is high.
- Constant elements (zero and one) are multiplied like any other element; there is no sparsity shortcut.

## Timing
- Call the edge on which the input handshake occurs edge 0.
- Edges 1..16 perform the MACs. Rows complete on edges 4, 8, 12 and 16.
- `out_valid` is high in the cycle after edge 16.
- Latency is 16 cycles from the accept edge to `out_valid`.
- The minimum vertex period is 18 cycles: 16 CALC cycles, 1 DONE cycle with `out_ready` high, and 1 IDLE accept cycle.
- `out_ready` may be held low indefinitely. All outputs must stay unchanged until the output handshake.
- `out_ready` asserted outside DONE has no effect.
- **Reset values (async):**
  - state = IDLE, so `in_ready` = 1 and `out_valid` = 0.
  - `cnt` = 0 and acc = 0.
  - out_x/y/z/w = 0 and `overflow` = 0.
  - Latched matrix and vector = 0.
- **Reset mid-CALC or in DONE:** the vertex is discarded with no partial output. `in_ready` = 1 in the first cycle after `Reset` deasserts.

## Test plan
- **Identity matrix** (0x0100 on the diagonal), vertex (0x0180, 0xFE00, 0x0300) → out (0x0180, 0xFE00, 0x0300, 0x0100), `overflow` = 0, `out_valid` exactly 16 cycles after accept.
- **Projection matrix with inv_tan = 1, aspect = 1, zNear = 1, zFar = 3:**
  - Matrix: diagonal (0x0100, 0x0100, 0xFE00, 0x0000), [11] = 0x0300, [14] = 0x0100.
  - Vertex (2, 1, −2) = (0x0200, 0x0100, 0xFE00) → out (0x0200, 0x0100, 0x0700, 0xFE00).
- **Saturation:** m[0] = 0x7F00, other elements identity, vertex x = 0x0200 → out_x = 0x7FFF, `overflow` = 1. The next vertex with identity input has `overflow` = 0.
- **Backpressure:** hold `out_ready` = 0 for 10 cycles in DONE while toggling `in_valid`, `in_x` and the matrix → out_* stable, `in_ready` = 0, no input consumed. Release → IDLE on the next cycle.
- **Matrix change during CALC:** swap the matrix to all-zero 3 cycles after accept → result equals the pre-swap matrix result.
- **Reset at edge 8 of CALC** → `out_valid` = 0 and outputs 0 immediately. After release, `in_ready` = 1 and a fresh vertex computes correctly.
